// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data-bus responder and the MEM stage that
// talks to it: responder FSM state encoding, byte-select patterns and the
// lane-alignment rule both sides must agree on.
package data_bus_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Base byte-select patterns for lane 0; other lanes are these shifted up.
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // A select is legal only if it is a byte, half or word pattern sitting on
  // the lanes that the low address bits point at. Halfwords only look at
  // addr[1]; anything that is not one of the listed patterns (including an
  // empty select) is a fault.
  function automatic logic sel_misaligned(input logic [3:0] sel, input logic [1:0] offset);
    logic bad;
    case (sel)
      SEL_WORD:                    bad = (offset != 2'd0);
      SEL_HALF:                    bad = offset[1];
      {SEL_HALF[1:0], 2'b00}:      bad = !offset[1];
      SEL_BYTE:                    bad = (offset != 2'd0);
      {SEL_BYTE[2:0], 1'b0}:       bad = (offset != 2'd1);
      {SEL_BYTE[1:0], 2'b00}:      bad = (offset != 2'd2);
      {SEL_BYTE[0], 3'b000}:       bad = (offset != 2'd3);
      default:                     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dbus_ram.sv
// Word-organised backing store for the data-bus responder.
// Ports:
//   clk      - write clock
//   rd_idx   - word index for the combinational read port
//   rd_data  - word at rd_idx
//   wr_en    - commit a write on the next rising edge
//   wr_idx   - word index for the write
//   wr_be    - byte enables, bit i writes lane i
//   wr_data  - lane-aligned write data
// Contents are deliberately not reset.
module dbus_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem_q [DEPTH_WORDS];

  assign rd_data = mem_q[rd_idx];

  // Byte-lane write: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-bus responder for the MEM stage: accepts one load/store at a time,
// inserts WAIT_CYCLES wait states, then strobes a one-cycle response.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   req_valid/req_we     - request present / store when 1
//   req_addr/req_sel     - byte address and lane enables
//   req_wdata            - lane-aligned store data
//   req_ready            - request accepted this cycle
//   resp_valid           - one-cycle response strobe
//   resp_rdata/resp_err  - load data / fault flag, valid with resp_valid
//   stallreq             - hold the pipeline while a request is in flight
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stallreq
);

  localparam int          AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_LIMIT = DEPTH_WORDS;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;

  logic          accept;
  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [3:0]    cur_sel;
  logic          cur_err;
  logic [AW-1:0] cur_idx;
  logic [31:0]   ram_rdata;
  logic          ram_we;

  // In IDLE the request is still on the bus and not yet latched, so the
  // zero-wait path reads the live inputs; afterwards the latched copy is used.
  always_comb begin
    accept   = (state_q == IDLE) && req_valid;
    cur_we   = (state_q == IDLE) ? req_we    : we_q;
    cur_addr = (state_q == IDLE) ? req_addr  : addr_q;
    cur_sel  = (state_q == IDLE) ? req_sel   : sel_q;
    cur_err  = ({2'b00, cur_addr[31:2]} >= DEPTH_LIMIT) || sel_misaligned(cur_sel, cur_addr[1:0]);
    // A faulted index may lie outside the array; park the port on word 0.
    cur_idx  = cur_err ? '0 : cur_addr[AW+1:2];
  end

  // Next-state logic; response data is captured on the edge entering RESP so
  // it stays stable for the whole strobe, and drops back to zero afterwards.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = '0;
    err_d   = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          sel_d   = req_sel;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
        ram_we  = we_q && !err_q && !reset;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if ((state_d == RESP) && (state_q != RESP)) begin
      err_d   = cur_err;
      rdata_d = (!cur_we && !cur_err) ? ram_rdata : 32'd0;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Latched copy of the accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  dbus_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk    (clk),
    .rd_idx (cur_idx),
    .rd_data(ram_rdata),
    .wr_en  (ram_we),
    .wr_idx (cur_idx),
    .wr_be  (sel_q),
    .wr_data(wdata_q)
  );

  // Outputs are forced quiet during the reset cycle itself.
  always_comb begin
    req_ready  = accept && !reset;
    stallreq   = (accept || (state_q == WAIT)) && !reset;
    resp_valid = (state_q == RESP) && !reset;
    resp_rdata = reset ? 32'd0 : rdata_q;
    resp_err   = err_q && !reset;
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: one instance with two wait
// states and one with none, driven by directed and random transactions and
// checked against a word-array reference model.
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_sel;
  bit          use0;

  logic        valid2, ready2, rv2, err2, stall2;
  logic [31:0] rdata2;
  logic        valid0, ready0, rv0, err0, stall0;
  logic [31:0] rdata0;

  logic        obs_ready, obs_rv, obs_err, obs_stall;
  logic [31:0] obs_rdata;

  logic [31:0] mdl [0:1][0:15];
  int          tests = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign valid2 = req_valid & ~use0;
  assign valid0 = req_valid & use0;

  data_bus_responder #(.WAIT_CYCLES(2), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .req_valid(valid2), .req_we(req_we),
    .req_addr(req_addr), .req_sel(req_sel), .req_wdata(req_wdata),
    .req_ready(ready2), .resp_valid(rv2), .resp_rdata(rdata2),
    .resp_err(err2), .stallreq(stall2)
  );

  data_bus_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(1024)) dut0 (
    .clk(clk), .reset(reset), .req_valid(valid0), .req_we(req_we),
    .req_addr(req_addr), .req_sel(req_sel), .req_wdata(req_wdata),
    .req_ready(ready0), .resp_valid(rv0), .resp_rdata(rdata0),
    .resp_err(err0), .stallreq(stall0)
  );

  // Observe whichever instance is currently being exercised.
  always_comb begin
    obs_ready = use0 ? ready0 : ready2;
    obs_rv    = use0 ? rv0    : rv2;
    obs_err   = use0 ? err0   : err2;
    obs_stall = use0 ? stall0 : stall2;
    obs_rdata = use0 ? rdata0 : rdata2;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s (dut%0d): got %h expected %h at %0t", tag, use0 ? 0 : 2, got, exp, $time);
    end
  endtask

  task automatic idleCycle();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    checkOutput("idle_rvalid", {31'd0, obs_rv}, 32'd0);
    checkOutput("idle_stall", {31'd0, obs_stall}, 32'd0);
  endtask

  // One complete transaction with cycle-by-cycle checks. hold keeps
  // req_valid high (with junk fields) after acceptance; reset_at > 0 pulses
  // reset during that wait cycle and aborts the transaction.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] wdata, input bit hold, input int reset_at);
    int          d, w, n, idx;
    logic        exp_err;
    logic [31:0] exp_rdata;
    d   = use0 ? 1 : 0;
    w   = use0 ? 0 : 2;
    n   = $countones(sel);
    idx = int'(addr[31:2]);
    exp_err = (idx >= 1024) ||
              !((n == 1 && sel == (4'd1 << addr[1:0])) ||
                (n == 2 && sel == (4'd3 << (2 * addr[1]))) ||
                (n == 4 && addr[1:0] == 2'd0));
    exp_rdata = (!we && !exp_err) ? mdl[d][idx[3:0]] : 32'd0;

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_sel = sel; req_wdata = wdata;
    #1;
    checkOutput("accept_ready", {31'd0, obs_ready}, 32'd1);
    checkOutput("accept_stall", {31'd0, obs_stall}, 32'd1);
    checkOutput("accept_rvalid", {31'd0, obs_rv}, 32'd0);

    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      req_valid = hold; req_we = 1'($urandom); req_addr = $urandom;
      req_sel = 4'($urandom); req_wdata = $urandom;
      if (k == reset_at) begin
        reset = 1'b1;
        #1;
        checkOutput("rst_ready", {31'd0, obs_ready}, 32'd0);
        checkOutput("rst_stall", {31'd0, obs_stall}, 32'd0);
        checkOutput("rst_rvalid", {31'd0, obs_rv}, 32'd0);
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0;
        #1;
        checkOutput("post_rst_rvalid", {31'd0, obs_rv}, 32'd0);
        checkOutput("post_rst_stall", {31'd0, obs_stall}, 32'd0);
        checkOutput("post_rst_rdata", obs_rdata, 32'd0);
        checkOutput("post_rst_err", {31'd0, obs_err}, 32'd0);
        return;
      end
      #1;
      checkOutput("wait_stall", {31'd0, obs_stall}, 32'd1);
      checkOutput("wait_ready", {31'd0, obs_ready}, 32'd0);
      checkOutput("wait_rvalid", {31'd0, obs_rv}, 32'd0);
    end

    @(negedge clk);
    req_valid = hold; req_we = 1'($urandom); req_addr = $urandom;
    req_sel = 4'($urandom); req_wdata = $urandom;
    #1;
    checkOutput("resp_rvalid", {31'd0, obs_rv}, 32'd1);
    checkOutput("resp_ready", {31'd0, obs_ready}, 32'd0);
    checkOutput("resp_stall", {31'd0, obs_stall}, 32'd0);
    checkOutput("resp_err", {31'd0, obs_err}, {31'd0, exp_err});
    checkOutput("resp_rdata", obs_rdata, exp_rdata);

    if (we && !exp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) mdl[d][idx[3:0]][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  // Random request over a 16-word pool, occasionally out of range.
  task automatic randomTransaction();
    logic [3:0]  sels [9] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h6};
    logic [3:0]  s;
    logic [31:0] a;
    logic [1:0]  off;
    s = sels[$urandom_range(0, 8)];
    if ($urandom_range(0, 1) == 0) off = 2'($urandom);
    else if (s == 4'hC || s == 4'h4) off = 2'd2;
    else if (s == 4'h2) off = 2'd1;
    else if (s == 4'h8) off = 2'd3;
    else off = 2'd0;
    if ($urandom_range(0, 7) == 0) a = {2'b00, 30'd1024 + 30'($urandom_range(0, 4095)), off};
    else a = {26'd0, 4'($urandom_range(0, 15)), off};
    applyStimulus(1'($urandom), a, s, $urandom, 1'($urandom), 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = '0; req_sel = 4'hF; req_wdata = '0;
    use0 = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_ready", {31'd0, obs_ready}, 32'd0);
    checkOutput("reset_stall", {31'd0, obs_stall}, 32'd0);
    checkOutput("reset_rvalid", {31'd0, obs_rv}, 32'd0);
    checkOutput("reset_rdata", obs_rdata, 32'd0);
    checkOutput("reset_err", {31'd0, obs_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;

    // Fill the word pool of both instances with known contents.
    for (int d = 0; d < 2; d++) begin
      use0 = (d == 1);
      for (int i = 0; i < 16; i++) begin
        applyStimulus(1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0, 0);
      end
      idleCycle();
    end

    // Directed scenarios on the two-wait-state instance.
    use0 = 1'b0;
    applyStimulus(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 0);
    applyStimulus(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 0);
    applyStimulus(1'b1, 32'h13, 4'h8, 32'h11000000, 1'b0, 0);
    applyStimulus(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 0);
    checkOutput("merged_word", mdl[0][4], 32'h11ADBEEF);
    applyStimulus(1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, 0);
    applyStimulus(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b1, 0);
    applyStimulus(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 0);
    applyStimulus(1'b1, 32'h20, 4'hF, 32'h12345678, 1'b0, 1);
    applyStimulus(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 0);
    applyStimulus(1'b1, 32'h24, 4'h0, 32'hFFFFFFFF, 1'b0, 0);
    applyStimulus(1'b0, 32'h24, 4'hF, 32'h0, 1'b0, 0);
    idleCycle();

    // Zero-wait instance: held request during RESP must be ignored.
    use0 = 1'b1;
    applyStimulus(1'b0, 32'h8, 4'hF, 32'h0, 1'b1, 0);
    applyStimulus(1'b1, 32'h8, 4'h3, 32'h0000ABCD, 1'b1, 0);
    applyStimulus(1'b0, 32'h8, 4'hF, 32'h0, 1'b0, 0);
    idleCycle();

    for (int d = 0; d < 2; d++) begin
      use0 = (d == 1);
      for (int i = 0; i < 60; i++) randomTransaction();
      idleCycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
